// File: rtl/stw_sweep_controller.sv
// Stop-the-World BIST sequencer: applies one or all entries of a programmable pattern table to the
// systolic array's STW ports and folds every per-PE result into a sticky fault map.
module stw_sweep_controller #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int WORD_SIZE    = 16,
  parameter int NUM_PATTERNS = 4,
  parameter int TIMEOUT      = 64,
  localparam int IW = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
  localparam int PE = ROWS * COLS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [1:0]             mode,
  input  logic [IW-1:0]          pattern_sel,
  input  logic                   pat_wr_en,
  input  logic [IW-1:0]          pat_wr_idx,
  input  logic [4*WORD_SIZE-1:0] pat_wr_data,
  output logic                   STW_test_load_en,
  output logic [WORD_SIZE-1:0]   STW_mult_op1,
  output logic [WORD_SIZE-1:0]   STW_mult_op2,
  output logic [WORD_SIZE-1:0]   STW_add_op,
  output logic [WORD_SIZE-1:0]   STW_expected,
  output logic                   STW_start,
  input  logic                   STW_complete,
  input  logic [PE-1:0]          STW_result_mat,
  output logic [PE-1:0]          fault_map,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout_err,
  output logic [7:0]             sweep_count
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PATTERNS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_ACCUM  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [1:0] M_SINGLE = 2'b00;
  localparam logic [1:0] M_CONT   = 2'b10;

  logic [2:0]             state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   skip_q, skip_d;
  logic [PE-1:0]          fault_q, fault_d;
  logic                   terr_q, terr_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [4*WORD_SIZE-1:0] ops_q;
  logic [4*WORD_SIZE-1:0] ops;
  logic [4*WORD_SIZE-1:0] pat_tbl_q [NUM_PATTERNS];
  logic [IW-1:0]          sel_clamped;
  logic                   wr_idx_ok;

  // Index range guards only exist when the index width can encode unused entries.
  if ((1 << IW) > NUM_PATTERNS) begin : g_idx_guard
    assign sel_clamped = (pattern_sel > LAST_IDX) ? LAST_IDX : pattern_sel;
    assign wr_idx_ok   = (pat_wr_idx <= LAST_IDX);
  end else begin : g_idx_full
    assign sel_clamped = pattern_sel;
    assign wr_idx_ok   = 1'b1;
  end

  // NOTE: the table is a small register file, so it takes the async reset like any other state;
  // a RAM-style table without reset would leave X operands after power-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PATTERNS; i++) pat_tbl_q[i] <= '0;
    end else if (pat_wr_en && wr_idx_ok && (state_q == S_IDLE)) begin
      pat_tbl_q[pat_wr_idx] <= pat_wr_data;
    end
  end

  // NOTE: every next-state variable gets its hold value first, so no path through the case
  // statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    skip_d  = skip_q;
    fault_d = fault_q;
    terr_d  = terr_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_d  = mode;
            idx_d   = (mode == M_SINGLE) ? sel_clamped : '0;
            fault_d = '1;
            terr_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_LOAD;
          end
        end
        S_LOAD:   state_d = S_LAUNCH;
        S_LAUNCH: begin
          timer_d = '0;
          skip_d  = 1'b0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          // First WAIT cycle still sees the previous test's complete level.
          if ((timer_q != '0) && STW_complete) begin
            state_d = S_ACCUM;
          end else if (timer_q == TMO_LAST) begin
            terr_d  = 1'b1;
            fault_d = '0;
            skip_d  = 1'b1;
            state_d = S_ACCUM;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_ACCUM: begin
          if (!skip_q) fault_d = fault_q & STW_result_mat;
          if ((mode_q == M_SINGLE) || (idx_q == LAST_IDX)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end
        end
        S_DONE: begin
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          if (mode_q == M_CONT) begin
            idx_d   = '0;
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      skip_q  <= 1'b0;
      fault_q <= '1;
      terr_q  <= 1'b0;
      cnt_q   <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      skip_q  <= skip_d;
      fault_q <= fault_d;
      terr_q  <= terr_d;
      cnt_q   <= cnt_d;
      if (state_q == S_LOAD) ops_q <= pat_tbl_q[idx_q];
    end
  end

  // Operands are live from the table during LOAD and held afterwards until the next LOAD.
  assign ops = (state_q == S_LOAD) ? pat_tbl_q[idx_q] : ops_q;

  assign STW_mult_op1     = ops[WORD_SIZE-1:0];
  assign STW_mult_op2     = ops[2*WORD_SIZE-1:WORD_SIZE];
  assign STW_add_op       = ops[3*WORD_SIZE-1:2*WORD_SIZE];
  assign STW_expected     = ops[4*WORD_SIZE-1:3*WORD_SIZE];
  assign STW_test_load_en = (state_q == S_LOAD);
  assign STW_start        = (state_q == S_LAUNCH);
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);
  assign fault_map        = fault_q;
  assign timeout_err      = terr_q;
  assign sweep_count      = cnt_q;

endmodule

// File: tb/tb_stw_sweep_controller.sv
// Self-checking bench for stw_sweep_controller: table-driven single-pattern runs plus
// hand-written sweep, timeout, continuous, stale-complete, write-lockout and reset sequences.
module tb_stw_sweep_controller;

  localparam int W  = 16;
  localparam int PE = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort;
  logic [1:0]    mode;
  logic [1:0]    pattern_sel;
  logic          pat_wr_en;
  logic [1:0]    pat_wr_idx;
  logic [4*W-1:0] pat_wr_data;
  logic          STW_test_load_en;
  logic [W-1:0]  STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected;
  logic          STW_start;
  logic          STW_complete;
  logic [PE-1:0] STW_result_mat;
  logic [PE-1:0] fault_map;
  logic          busy, done, timeout_err;
  logic [7:0]    sweep_count;

  stw_sweep_controller #(
    .ROWS(4), .COLS(4), .WORD_SIZE(W), .NUM_PATTERNS(4), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .pattern_sel(pattern_sel), .pat_wr_en(pat_wr_en), .pat_wr_idx(pat_wr_idx),
    .pat_wr_data(pat_wr_data), .STW_test_load_en(STW_test_load_en),
    .STW_mult_op1(STW_mult_op1), .STW_mult_op2(STW_mult_op2), .STW_add_op(STW_add_op),
    .STW_expected(STW_expected), .STW_start(STW_start), .STW_complete(STW_complete),
    .STW_result_mat(STW_result_mat), .fault_map(fault_map), .busy(busy), .done(done),
    .timeout_err(timeout_err), .sweep_count(sweep_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] res;
    logic [15:0] op1, op2, add, expv;
    logic [15:0] fmap;
  } vec_t;

  vec_t        vecs [4];
  logic [15:0] results [16];
  int checks = 0, errors = 0;
  int n_load = 0, n_done = 0;
  int launch_cnt = 0, since_start = 0, resp_delay = 2, hang_idx = -1;
  bit stuck = 0;
  int cyc, cyc2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: observe outputs at the falling edge, then drive the array model's response.
  task automatic step();
    @(negedge clk);
    if (STW_test_load_en) n_load++;
    if (done) n_done++;
    if (STW_start) begin
      launch_cnt++;
      since_start = 0;
    end else if (since_start < 1000) begin
      since_start++;
    end
    if (stuck) STW_complete = 1'b1;
    else STW_complete = (launch_cnt > 0) && ((launch_cnt - 1) != hang_idx) &&
                        (since_start >= resp_delay);
    STW_result_mat = (launch_cnt > 0) ? results[(launch_cnt - 1) % 16] : 16'hFFFF;
  endtask

  task automatic start_run(input logic [1:0] m, input logic [1:0] sel);
    launch_cnt  = 0;
    since_start = 0;
    mode        = m;
    pattern_sel = sel;
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int n);
    int base;
    base = n_done;
    n = 0;
    while ((n_done == base) && (n < budget)) begin
      step();
      n++;
    end
    check(name, 64'(n_done - base), 64'd1);
  endtask

  task automatic write_pat(input logic [1:0] idx, input logic [15:0] e, input logic [15:0] a,
                           input logic [15:0] o2, input logic [15:0] o1);
    pat_wr_en   = 1'b1;
    pat_wr_idx  = idx;
    pat_wr_data = {e, a, o2, o1};
    step();
    pat_wr_en   = 1'b0;
  endtask

  initial begin
    vecs[0] = '{sel: 2'd0, res: 16'hFFFF, op1: 16'd4,    op2: 16'd3,  add: 16'd1,    expv: 16'd13,   fmap: 16'hFFFF};
    vecs[1] = '{sel: 2'd1, res: 16'hFFFB, op1: 16'd6,    op2: 16'd6,  add: 16'd2,    expv: 16'h0026, fmap: 16'hFFFB};
    vecs[2] = '{sel: 2'd2, res: 16'h0001, op1: 16'd100,  op2: 16'd30, add: 16'd0,    expv: 16'h0BB8, fmap: 16'h0001};
    vecs[3] = '{sel: 2'd3, res: 16'hA5A5, op1: 16'h1234, op2: 16'd0,  add: 16'hFFFF, expv: 16'hFFFF, fmap: 16'hA5A5};
    for (int i = 0; i < 16; i++) results[i] = 16'hFFFF;

    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00; pattern_sel = '0;
    pat_wr_en = 1'b0; pat_wr_idx = '0; pat_wr_data = '0;
    STW_complete = 1'b0; STW_result_mat = '1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_load_en", STW_test_load_en, 0);
    check("rst_stw_start", STW_start, 0);
    check("rst_fault_map", fault_map, 16'hFFFF);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_sweep_count", sweep_count, 0);
    check("rst_op1", STW_mult_op1, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 4; i++)
      write_pat(vecs[i].sel, vecs[i].expv, vecs[i].add, vecs[i].op2, vecs[i].op1);

    // Single-pattern runs from the vector table.
    for (int i = 0; i < 4; i++) begin
      resp_delay = 2;
      results[0] = vecs[i].res;
      start_run(2'b00, vecs[i].sel);
      check("v_load_en", STW_test_load_en, 1);
      check("v_op1", STW_mult_op1, vecs[i].op1);
      check("v_op2", STW_mult_op2, vecs[i].op2);
      check("v_add", STW_add_op, vecs[i].add);
      check("v_exp", STW_expected, vecs[i].expv);
      step();
      check("v_stw_start", STW_start, 1);
      check("v_op1_held", STW_mult_op1, vecs[i].op1);
      wait_done("v_done", 50, cyc);
      check("v_done_latency", 64'(cyc + 2), 64'd6);
      check("v_fault_map", fault_map, vecs[i].fmap);
      step();
      check("v_done_pulse_width", done, 0);
      check("v_sweep_count", sweep_count, 1);
      check("v_busy_after", busy, 0);
    end
    results[0] = 16'hFFFF;

    // Sweep all once.
    results[1] = 16'hFFFB; results[3] = 16'h7FFF;
    n_load = 0; n_done = 0;
    start_run(2'b01, 2'd2);
    wait_done("sw_done", 100, cyc);
    check("sw_load_count", 64'(n_load), 64'd4);
    check("sw_fault_map", fault_map, 16'h7FFB);
    repeat (3) step();
    check("sw_done_count", 64'(n_done), 64'd1);
    check("sw_busy", busy, 0);
    check("sw_sweep_count", sweep_count, 1);
    results[1] = 16'hFFFF; results[3] = 16'hFFFF;

    // Timeout on pattern index 2 of a sweep.
    hang_idx = 2; n_load = 0;
    start_run(2'b01, 2'd0);
    wait_done("to_done", 200, cyc);
    check("to_latency", 64'(cyc + 1), 64'd83);
    check("to_timeout_err", timeout_err, 1);
    check("to_fault_map", fault_map, 16'h0000);
    check("to_load_count", 64'(n_load), 64'd4);
    step();
    check("to_timeout_sticky", timeout_err, 1);
    hang_idx = -1;

    // Continuous sweep, then abort in WAIT.
    results[4] = 16'hEFFF; n_done = 0;
    start_run(2'b10, 2'd0);
    wait_done("ct_done1", 100, cyc);
    check("ct_period1", 64'(cyc + 1), 64'd21);
    check("ct_fault1", fault_map, 16'hFFFF);
    step();
    check("ct_count1", sweep_count, 1);
    check("ct_busy", busy, 1);
    wait_done("ct_done2", 100, cyc2);
    check("ct_period2", 64'(cyc2 + 1), 64'd21);
    check("ct_fault2", fault_map, 16'hEFFF);
    step();
    check("ct_count2", sweep_count, 2);
    repeat (2) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_load_en", STW_test_load_en, 0);
    check("ab_stw_start", STW_start, 0);
    repeat (25) step();
    check("ab_no_extra_done", 64'(n_done), 64'd2);
    check("ab_fault_held", fault_map, 16'hEFFF);
    check("ab_count_held", sweep_count, 2);
    results[4] = 16'hFFFF;

    // STW_complete stuck high from before start.
    stuck = 1; results[0] = 16'hFFF0;
    step();
    start_run(2'b00, 2'd0);
    wait_done("st_done", 50, cyc);
    check("st_latency", 64'(cyc + 1), 64'd6);
    check("st_fault_map", fault_map, 16'hFFF0);
    stuck = 0; results[0] = 16'hFFFF;
    step();

    // Writes and start while busy are ignored.
    resp_delay = 4; n_load = 0;
    start_run(2'b00, 2'd1);
    pat_wr_en = 1'b1; pat_wr_idx = 2'd1; pat_wr_data = 64'hDEAD_BEEF_CAFE_F00D;
    start = 1'b1;
    step();
    pat_wr_en = 1'b0; start = 1'b0;
    wait_done("wl_done", 50, cyc);
    step();
    check("wl_load_count", 64'(n_load), 64'd1);
    resp_delay = 2;
    start_run(2'b00, 2'd1);
    check("wl_op1_kept", STW_mult_op1, 16'd6);
    check("wl_exp_kept", STW_expected, 16'h0026);
    wait_done("wl_done2", 50, cyc);
    step();

    // Write and start in the same IDLE cycle: run uses the new entry.
    pat_wr_en = 1'b1; pat_wr_idx = 2'd2; pat_wr_data = {16'h0044, 16'd5, 16'd7, 16'd9};
    start_run(2'b00, 2'd2);
    pat_wr_en = 1'b0;
    check("ws_op1_new", STW_mult_op1, 16'd9);
    check("ws_add_new", STW_add_op, 16'd5);
    wait_done("ws_done", 50, cyc);
    step();

    // Asynchronous reset in WAIT of the second pattern of a sweep.
    results[0] = 16'h0F0F;
    start_run(2'b01, 2'd0);
    repeat (7) step();
    check("rr_pre_fault", fault_map, 16'h0F0F);
    check("rr_pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("rr_busy", busy, 0);
    check("rr_fault_map", fault_map, 16'hFFFF);
    check("rr_load_en", STW_test_load_en, 0);
    check("rr_stw_start", STW_start, 0);
    check("rr_op1", STW_mult_op1, 0);
    step();
    rst = 1'b0;
    results[0] = 16'hFFFF;
    step();
    start_run(2'b00, 2'd3);
    check("rr_table_op1", STW_mult_op1, 0);
    check("rr_table_exp", STW_expected, 0);
    wait_done("rr_done", 50, cyc);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
